// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl
// Miss sequencer and pipeline-advance controller for the 5-stage MIPS core.
// One main-memory read port is shared between I-cache and D-cache line
// refills, with the D side winning when both miss together. The block drives
// the global advance enable (hit) and the branch flush. A flush that arrives
// while the pipeline is stalled is held and issued on the first advancing cycle.
//
// Optional build macro: MEM_STALL_PERF_EN adds saturating performance counters
// (stall_cycles, i_miss_cnt, d_miss_cnt). Without it those ports do not exist.

module mem_stall_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          icache_miss,
  input  logic [ADDR_W-1:0]             icache_addr,
  input  logic                          dcache_miss,
  input  logic [ADDR_W-1:0]             dcache_addr,
  input  logic                          branch_taken,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_ack,
  output logic                          refill_i_we,
  output logic                          refill_d_we,
  output logic [$clog2(LINE_WORDS)-1:0] refill_word,
  output logic                          hit,
  output logic                          flush
`ifdef MEM_STALL_PERF_EN
  ,
  output logic [31:0]                   stall_cycles,
  output logic [15:0]                   i_miss_cnt,
  output logic [15:0]                   d_miss_cnt
`endif
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  // Byte offset bits covered by one cache line.
  localparam int OFF_W  = WORD_W + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_D = 2'd1,
    FILL_I = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_reg;
  logic                flush_pend_reg;
  logic [ADDR_W-1:0]   line_mask;
  logic                beat_ok;
  logic                last_beat;

  // Clears the in-line offset so a burst always starts at the line base.
  assign line_mask = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  // A beat only counts while a request is outstanding.
  assign beat_ok   = mem_req & mem_ack;
  assign last_beat = (refill_word == WORD_W'(LINE_WORDS - 1));

  // Advance enable, beat write strobes and the flush are purely combinational.
  always_comb begin
    hit         = (state_reg == IDLE) & ~icache_miss & ~dcache_miss;
    refill_d_we = beat_ok & (state_reg == FILL_D);
    refill_i_we = beat_ok & (state_reg == FILL_I);
    flush       = hit & (branch_taken | flush_pend_reg);
  end

  // Miss sequencer: pick a side, stream LINE_WORDS beats, then one bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      refill_word <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (dcache_miss) begin
            state_reg   <= FILL_D;
            mem_req     <= 1'b1;
            mem_addr    <= dcache_addr & line_mask;
            refill_word <= '0;
          end else if (icache_miss) begin
            state_reg   <= FILL_I;
            mem_req     <= 1'b1;
            mem_addr    <= icache_addr & line_mask;
            refill_word <= '0;
          end
        end
        FILL_D, FILL_I: begin
          // Wait states from memory simply hold the beat counter and address.
          if (beat_ok) begin
            refill_word <= refill_word + WORD_W'(1);
            mem_addr    <= mem_addr + ADDR_W'(4);
            if (last_beat) begin
              mem_req   <= 1'b0;
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          // Bubble cycle so the cache can re-look-up the freshly filled line.
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

  // Remember a taken branch seen while stalled; drop it once the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend_reg <= 1'b0;
    end else if (hit) begin
      flush_pend_reg <= 1'b0;
    end else if (branch_taken) begin
      flush_pend_reg <= 1'b1;
    end
  end

`ifdef MEM_STALL_PERF_EN
  logic start_d;
  logic start_i;

  assign start_d = (state_reg == IDLE) & dcache_miss;
  assign start_i = (state_reg == IDLE) & ~dcache_miss & icache_miss;

  // Saturating stall and miss counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      i_miss_cnt   <= '0;
      d_miss_cnt   <= '0;
    end else begin
      if (!hit && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (start_d && (d_miss_cnt != '1)) begin
        d_miss_cnt <= d_miss_cnt + 16'd1;
      end
      if (start_i && (i_miss_cnt != '1)) begin
        i_miss_cnt <= i_miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed testbench for mem_stall_ctrl (LINE_WORDS=4, ADDR_W=32).
// Inputs change 1 time unit after the rising edge; outputs are checked one
// further time unit later, well away from the next edge.

module tb_mem_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icache_miss;
  logic [31:0] icache_addr;
  logic        dcache_miss;
  logic [31:0] dcache_addr;
  logic        branch_taken;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        refill_i_we;
  logic        refill_d_we;
  logic [1:0]  refill_word;
  logic        hit;
  logic        flush;
`ifdef MEM_STALL_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] i_miss_cnt;
  logic [15:0] d_miss_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int hit_lo  = 0;

  always #5 clk = ~clk;

  mem_stall_ctrl #(
    .LINE_WORDS (4),
    .ADDR_W     (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .icache_miss  (icache_miss),
    .icache_addr  (icache_addr),
    .dcache_miss  (dcache_miss),
    .dcache_addr  (dcache_addr),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .refill_i_we  (refill_i_we),
    .refill_d_we  (refill_d_we),
    .refill_word  (refill_word),
    .hit          (hit),
    .flush        (flush)
`ifdef MEM_STALL_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .i_miss_cnt   (i_miss_cnt),
    .d_miss_cnt   (d_miss_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle;
    #1;
  endtask

`ifdef MEM_STALL_PERF_EN
  // Full miss with memory acking every beat; miss drops in the DONE bubble.
  task automatic do_miss(input bit is_d, input logic [31:0] addr);
    if (is_d) begin dcache_miss = 1'b1; dcache_addr = addr; end
    else      begin icache_miss = 1'b1; icache_addr = addr; end
    mem_ack = 1'b1;
    tick;
    for (int k = 0; k < 4; k++) tick;
    dcache_miss = 1'b0;
    icache_miss = 1'b0;
    tick;
    settle;
    check_val("perf_idle_hit", 32'(hit), 32'd1);
  endtask
`endif

  int          pat_ack [7] = '{1, 0, 0, 1, 1, 0, 1};
  int          pat_rw  [7] = '{0, 1, 1, 1, 2, 3, 3};

  initial begin
    rst_n        = 1'b0;
    icache_miss  = 1'b0;
    icache_addr  = '0;
    dcache_miss  = 1'b0;
    dcache_addr  = '0;
    branch_taken = 1'b0;
    mem_ack      = 1'b0;

    // ---------------- reset state ----------------
    #2;
    check_val("rst_mem_req",     32'(mem_req),     32'd0);
    check_val("rst_mem_addr",    mem_addr,         32'd0);
    check_val("rst_refill_word", 32'(refill_word), 32'd0);
    check_val("rst_hit",         32'(hit),         32'd1);
    check_val("rst_flush",       32'(flush),       32'd0);
    icache_miss = 1'b1;
    settle;
    check_val("rst_hit_imiss",   32'(hit),         32'd0);
    icache_miss = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    $display("[TB] reset checks done");

    // ---------------- D miss, ack every cycle ----------------
    hit_lo      = 0;
    dcache_miss = 1'b1;
    dcache_addr = 32'h0000_1234;
    mem_ack     = 1'b1;           // ignored: no request yet
    settle;
    check_val("d_idle_hit",     32'(hit),         32'd0);
    check_val("d_idle_req",     32'(mem_req),     32'd0);
    check_val("d_idle_we",      32'(refill_d_we), 32'd0);
    if (!hit) hit_lo++;
    tick;
    for (int k = 0; k < 4; k++) begin
      settle;
      check_val("d_addr",  mem_addr,             32'h0000_1230 + 32'(4 * k));
      check_val("d_word",  32'(refill_word),     32'(k));
      check_val("d_we",    32'(refill_d_we),     32'd1);
      check_val("d_i_we",  32'(refill_i_we),     32'd0);
      check_val("d_req",   32'(mem_req),         32'd1);
      if (!hit) hit_lo++;
      tick;
    end
    dcache_miss = 1'b0;           // line now present
    settle;
    check_val("d_done_req",  32'(mem_req),     32'd0);
    check_val("d_done_word", 32'(refill_word), 32'd0);
    check_val("d_done_we",   32'(refill_d_we), 32'd0);
    check_val("d_done_hit",  32'(hit),         32'd0);
    if (!hit) hit_lo++;
    tick;
    settle;
    check_val("d_back_hit",  32'(hit),         32'd1);
    check_val("d_stall_len", 32'(hit_lo),      32'd6);
    mem_ack = 1'b0;
    tick;
    $display("[TB] D miss 0x1234 done, stall=%0d", hit_lo);

    // ---------------- simultaneous I + D miss ----------------
    icache_miss = 1'b1;
    icache_addr = 32'h0000_0040;
    dcache_miss = 1'b1;
    dcache_addr = 32'h0000_2000;
    mem_ack     = 1'b1;
    tick;
    for (int k = 0; k < 4; k++) begin
      settle;
      check_val("both_d_addr", mem_addr,         32'h0000_2000 + 32'(4 * k));
      check_val("both_d_we",   32'(refill_d_we), 32'd1);
      check_val("both_i_we",   32'(refill_i_we), 32'd0);
      tick;
    end
    dcache_miss = 1'b0;
    settle;
    check_val("both_done_hit", 32'(hit), 32'd0);
    tick;
    settle;
    check_val("both_idle_req", 32'(mem_req), 32'd0);
    check_val("both_idle_hit", 32'(hit),     32'd0);
    tick;
    for (int k = 0; k < 4; k++) begin
      settle;
      check_val("both_i_addr",  mem_addr,         32'h0000_0040 + 32'(4 * k));
      check_val("both_i_we2",   32'(refill_i_we), 32'd1);
      check_val("both_d_we2",   32'(refill_d_we), 32'd0);
      tick;
    end
    icache_miss = 1'b0;
    tick;
    settle;
    check_val("both_end_hit", 32'(hit), 32'd1);
    mem_ack = 1'b0;
    tick;
    $display("[TB] simultaneous I+D miss done");

    // ---------------- wait states ----------------
    dcache_miss = 1'b1;
    dcache_addr = 32'h0000_0108;
    tick;
    for (int k = 0; k < 7; k++) begin
      mem_ack = pat_ack[k][0];
      settle;
      check_val("ws_word", 32'(refill_word), 32'(pat_rw[k]));
      check_val("ws_addr", mem_addr,         32'h0000_0100 + 32'(4 * pat_rw[k]));
      check_val("ws_we",   32'(refill_d_we), 32'(pat_ack[k]));
      tick;
    end
    dcache_miss = 1'b0;
    mem_ack     = 1'b1;           // ack with no request must be ignored
    settle;
    check_val("ws_done_req", 32'(mem_req),     32'd0);
    check_val("ws_done_we",  32'(refill_d_we), 32'd0);
    tick;
    mem_ack = 1'b0;
    settle;
    check_val("ws_end_hit", 32'(hit), 32'd1);
    tick;
    $display("[TB] wait-state burst done");

    // ---------------- branch during stall ----------------
    icache_miss = 1'b1;
    icache_addr = 32'h0000_0080;
    tick;
    branch_taken = 1'b1;
    settle;
    check_val("br_stall_flush", 32'(flush), 32'd0);
    tick;
    branch_taken = 1'b0;
    mem_ack      = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle;
      check_val("br_fill_flush", 32'(flush), 32'd0);
      tick;
    end
    icache_miss = 1'b0;
    mem_ack     = 1'b0;
    settle;
    check_val("br_done_flush", 32'(flush), 32'd0);
    tick;
    settle;
    check_val("br_idle_flush", 32'(flush), 32'd1);
    tick;
    settle;
    check_val("br_once_flush", 32'(flush), 32'd0);
    branch_taken = 1'b1;          // taken branch while advancing
    settle;
    check_val("br_hit_flush",  32'(flush), 32'd1);
    tick;
    branch_taken = 1'b0;
    settle;
    check_val("br_no_pend",    32'(flush), 32'd0);
    tick;
    $display("[TB] branch flush deferral done");

    // ---------------- reset mid-burst ----------------
    dcache_miss = 1'b1;
    dcache_addr = 32'h0000_3000;
    tick;
    mem_ack      = 1'b1;
    branch_taken = 1'b1;          // leaves a pending flush behind
    tick;
    branch_taken = 1'b0;
    tick;
    settle;
    check_val("rmb_pre_word", 32'(refill_word), 32'd2);
    rst_n       = 1'b0;
    dcache_miss = 1'b0;
    mem_ack     = 1'b0;
    settle;
    check_val("rmb_req",   32'(mem_req),     32'd0);
    check_val("rmb_word",  32'(refill_word), 32'd0);
    check_val("rmb_addr",  mem_addr,         32'd0);
    check_val("rmb_hit",   32'(hit),         32'd1);
    check_val("rmb_flush", 32'(flush),       32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    settle;
    check_val("rmb_after_hit",   32'(hit),   32'd1);
    check_val("rmb_after_flush", 32'(flush), 32'd0);
    $display("[TB] reset mid-burst done");

`ifdef MEM_STALL_PERF_EN
    // ---------------- performance counters ----------------
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    do_miss(1'b1, 32'h0000_0500);
    do_miss(1'b1, 32'h0000_0600);
    do_miss(1'b0, 32'h0000_0700);
    settle;
    check_val("perf_d_cnt", 32'(d_miss_cnt), 32'd2);
    check_val("perf_i_cnt", 32'(i_miss_cnt), 32'd1);
    check_val("perf_stall", stall_cycles,    32'd18);
    $display("[TB] perf counters d=%0d i=%0d stall=%0d", d_miss_cnt, i_miss_cnt, stall_cycles);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
